// File: rtl/encoder_sequencer.sv
// encoder_sequencer: handshake-driven control for the 3-stage AV1 encoder pipeline; ENC_SEQ_STALL_EN adds bitstream back-pressure
module encoder_sequencer #(
  parameter int CNT_WIDTH    = 16,
  parameter int RANGE_WIDTH  = 16,
  parameter int SYMBOL_WIDTH = 4
) (
  input  logic                    general_clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [RANGE_WIDTH-1:0]  in_fl,
  input  logic [RANGE_WIDTH-1:0]  in_fh,
  input  logic [SYMBOL_WIDTH-1:0] in_symbol,
  input  logic [SYMBOL_WIDTH:0]   in_nsyms,
  input  logic                    in_bool,
  input  logic                    in_last,
  output logic [RANGE_WIDTH-1:0]  enc_fl,
  output logic [RANGE_WIDTH-1:0]  enc_fh,
  output logic [SYMBOL_WIDTH-1:0] enc_symbol,
  output logic [SYMBOL_WIDTH:0]   enc_nsyms,
  output logic                    enc_bool,
  output logic                    enc_reset,
  output logic                    en_1_2,
  output logic                    en_2_3,
  output logic                    en_final,
  input  logic [1:0]              enc_flag,
  output logic                    bs_valid,
  input  logic                    bs_ready,
  output logic                    done_valid,
  input  logic                    done_ready,
  output logic [CNT_WIDTH-1:0]    frame_symbols
);
  typedef enum logic [1:0] {INIT, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic v1, v2, v3, l1, l2, l3, stall, accept;
`ifdef ENC_SEQ_STALL_EN
  assign stall = v3 && (enc_flag != 2'b00) && !bs_ready;
`else
  logic unused_bs_ready;
  assign unused_bs_ready = bs_ready;
  assign stall = 1'b0;
`endif
  assign enc_fl     = in_fl;
  assign enc_fh     = in_fh;
  assign enc_symbol = in_symbol;
  assign enc_nsyms  = in_nsyms;
  assign enc_bool   = in_bool;
  assign accept     = in_valid && in_ready;
  assign en_1_2     = accept;
  assign en_2_3     = v1 && !stall;
  assign en_final   = v2 && !stall;
  assign bs_valid   = v3 && (enc_flag != 2'b00);
  // frame state register
  always_ff @(posedge general_clk)
    if (!reset) state <= INIT;
    else state <= state_nxt;
  // valid/last markers shadow the encoder pipeline and freeze with it
  always_ff @(posedge general_clk)
    if (!reset) {v1, v2, v3, l1, l2, l3} <= '0;
    else if (!stall) {v1, v2, v3, l1, l2, l3} <= {accept, v1, v2, accept && in_last, l1, l2};
  // saturating per-frame symbol counter, cleared while the encoder is reset
  always_ff @(posedge general_clk)
    if (!reset || state == INIT) frame_symbols <= '0;
    else if (accept && frame_symbols != '1) frame_symbols <= frame_symbols + 1'b1;
  // next state and per-state handshake outputs
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    enc_reset  = 1'b0;
    done_valid = 1'b0;
    case (state)
      INIT: begin
        enc_reset = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        in_ready  = !stall;
        state_nxt = (in_valid && !stall && in_last) ? DRAIN : RUN;
      end
      DRAIN: state_nxt = (l2 && !stall) ? DONE : DRAIN;
      default: begin
        done_valid = 1'b1;
        state_nxt  = done_ready ? INIT : DONE;
      end
    endcase
  end
endmodule

// File: tb/tb_encoder_sequencer.sv
// tb_encoder_sequencer: directed checks of frame bracketing, pipeline enables and bitstream qualification
module tb_encoder_sequencer;
  localparam int CW = 3, RW = 16, SW = 4;
  logic clk = 0, reset = 0;
  logic in_valid = 0, in_ready, in_bool = 0, in_last = 0;
  logic [RW-1:0] in_fl = 0, in_fh = 0, enc_fl, enc_fh;
  logic [SW-1:0] in_symbol = 0, enc_symbol;
  logic [SW:0] in_nsyms = 0, enc_nsyms;
  logic enc_bool, enc_reset, en_1_2, en_2_3, en_final, bs_valid, done_valid;
  logic [1:0] enc_flag = 0;
  logic bs_ready = 1, done_ready = 0;
  logic [CW-1:0] frame_symbols;
  logic [11:0] hf, hd, hb;
  logic [8:0] bf, b23, bd;
  int compared = 0, mismatched = 0;

  encoder_sequencer #(.CNT_WIDTH(CW), .RANGE_WIDTH(RW), .SYMBOL_WIDTH(SW)) dut (
    .general_clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_fl(in_fl), .in_fh(in_fh), .in_symbol(in_symbol), .in_nsyms(in_nsyms),
    .in_bool(in_bool), .in_last(in_last), .enc_fl(enc_fl), .enc_fh(enc_fh),
    .enc_symbol(enc_symbol), .enc_nsyms(enc_nsyms), .enc_bool(enc_bool),
    .enc_reset(enc_reset), .en_1_2(en_1_2), .en_2_3(en_2_3), .en_final(en_final),
    .enc_flag(enc_flag), .bs_valid(bs_valid), .bs_ready(bs_ready),
    .done_valid(done_valid), .done_ready(done_ready), .frame_symbols(frame_symbols)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset held for 3 cycles with a symbol offered
    in_valid = 1; in_fl = 16'h1234; in_fh = 16'h5678; in_symbol = 4'h5; in_nsyms = 5'd9; in_bool = 1;
    tick; tick; tick;
    chk("rst_enc_reset", enc_reset, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_en", {en_1_2, en_2_3, en_final}, 0);
    chk("rst_count", frame_symbols, 0);
    chk("rst_done_bs", {done_valid, bs_valid}, 0);
    chk("pass_through", {enc_fl, enc_fh, enc_symbol, enc_nsyms, enc_bool}, {16'h1234, 16'h5678, 4'h5, 5'd9, 1'b1});
    in_valid = 0; reset = 1; #1;
    chk("init_enc_reset", enc_reset, 1);
    chk("init_in_ready", in_ready, 0);
    tick;
    chk("run_in_ready", in_ready, 1);
    chk("run_enc_reset", enc_reset, 0);
    // single-symbol frame accepted at cycle A
    in_valid = 1; in_last = 1; #1;
    chk("single_en12", en_1_2, 1);
    tick; in_valid = 0; in_last = 0; #1;
    chk("single_en23", {en_1_2, en_2_3, en_final}, 3'b010);
    chk("drain_in_ready", in_ready, 0);
    chk("single_count", frame_symbols, 1);
    tick; in_valid = 1; #1;
    chk("single_enfinal", {en_1_2, en_2_3, en_final}, 3'b001);
    chk("drain_no_accept", en_1_2, 0);
    in_valid = 0;
    tick; enc_flag = 2'b10; #1;
    chk("single_done", done_valid, 1);
    chk("bs_valid_flag10", bs_valid, 1);
    enc_flag = 2'b00; #1;
    chk("bs_valid_flag00", bs_valid, 0);
    tick; enc_flag = 2'b10; #1;
    chk("done_hold", done_valid, 1);
    chk("bs_after_v3", bs_valid, 0);
    done_ready = 1; enc_flag = 2'b00;
    tick; done_ready = 0; #1;
    chk("gap_init", {enc_reset, in_ready, done_valid}, 3'b100);
    tick;
    chk("gap_run", {in_ready, frame_symbols}, {1'b1, 3'd0});
    // streaming 8 symbols; counter is 3 bits wide so it saturates at 7
`ifdef ENC_SEQ_STALL_EN
    bs_ready = 1;
`else
    bs_ready = 0;
`endif
    enc_flag = 2'b01;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 8); in_last = (c == 7); #1;
      hf[c] = en_final; hd[c] = done_valid; hb[c] = bs_valid;
      tick;
    end
    in_valid = 0; in_last = 0; enc_flag = 2'b00; bs_ready = 1;
    chk("stream_en_final", hf, 12'b0011_1111_1100);
    chk("stream_done", hd, 12'b1100_0000_0000);
    chk("stream_bs_valid", hb, 12'b0111_1111_1000);
    chk("stream_count_sat", frame_symbols, 7);
    done_ready = 1; tick; done_ready = 0; tick;
    // bubbles: symbols at cycles 0, 3, 4
    for (int c = 0; c < 9; c++) begin
      in_valid = (c == 0 || c == 3 || c == 4); in_last = (c == 4); #1;
      bf[c] = en_final; b23[c] = en_2_3; bd[c] = done_valid;
      tick;
    end
    in_valid = 0; in_last = 0;
    chk("bubble_en_final", bf, 9'b001100100);
    chk("bubble_en23", b23, 9'b000110010);
    chk("bubble_done", bd, 9'b110000000);
    chk("bubble_count", frame_symbols, 3);
    done_ready = 1; tick; done_ready = 0; tick;
    // reset in the middle of a frame drops in-flight symbols
    in_valid = 1; tick; tick; #1;
    chk("mid_inflight", {en_1_2, en_2_3, en_final}, 3'b111);
    reset = 0; in_valid = 0; tick; reset = 1; enc_flag = 2'b10; #1;
    chk("mid_flushed", {en_2_3, en_final, bs_valid}, 0);
    chk("mid_enc_reset", enc_reset, 1);
    chk("mid_count", frame_symbols, 0);
    enc_flag = 2'b00;
    tick; tick; tick;
    chk("mid_no_done", {done_valid, in_ready}, 2'b01);
`ifdef ENC_SEQ_STALL_EN
    begin
      int nf = 0;
      enc_flag = 2'b01; bs_ready = 0;
      for (int c = 0; c < 11; c++) begin
        in_valid = (c < 3); in_last = (c == 2);
        if (c == 7) bs_ready = 1;
        #1;
        if (c >= 3 && c <= 6) begin
          chk("stall_frozen", {en_1_2, en_2_3, en_final, in_ready}, 0);
          chk("stall_bs_held", bs_valid, 1);
        end
        if (c == 9) chk("stall_done", done_valid, 1);
        nf += int'(en_final);
        tick;
      end
      in_valid = 0; in_last = 0;
      chk("stall_en_final_count", nf, 3);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
